// File: rtl/instr_queue_split_pkg.sv
// Shared MIPS field layout and NOP encoding for the F/D instruction queue.
package instr_queue_split_pkg;

  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SH_LSB    = 6;
  localparam int unsigned FUNCT_LSB = 0;
  localparam int unsigned OP_W      = 6;
  localparam int unsigned REG_W     = 5;
  localparam int unsigned FUNCT_W   = 6;
  localparam int unsigned IMM16_W   = 16;
  localparam int unsigned IMM26_W   = 26;

  localparam logic [31:0] NOP = 32'h0;

  typedef struct packed {
    logic [OP_W-1:0]    op;
    logic [REG_W-1:0]   rs;
    logic [REG_W-1:0]   rt;
    logic [REG_W-1:0]   rd;
    logic [REG_W-1:0]   shamt;
    logic [FUNCT_W-1:0] funct;
    logic [IMM16_W-1:0] imm16;
    logic [IMM26_W-1:0] imm26;
  } fields_t;

  function automatic fields_t split_fields(input logic [31:0] instr);
    fields_t f;
    f.op    = instr[OP_LSB    +: OP_W];
    f.rs    = instr[RS_LSB    +: REG_W];
    f.rt    = instr[RT_LSB    +: REG_W];
    f.rd    = instr[RD_LSB    +: REG_W];
    f.shamt = instr[SH_LSB    +: REG_W];
    f.funct = instr[FUNCT_LSB +: FUNCT_W];
    f.imm16 = instr[0 +: IMM16_W];
    f.imm26 = instr[0 +: IMM26_W];
    return f;
  endfunction

endpackage

// File: rtl/instr_queue_split_field.sv
// Combinational split of a 32-bit MIPS instruction into its fixed-position fields.
module instr_field_split
  import instr_queue_split_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [4:0]  s,
  output logic [5:0]  funct,
  output logic [15:0] imm16,
  output logic [25:0] imm26
);

  fields_t f;

  always_comb begin
    f     = split_fields(instr);
    op    = f.op;
    rs    = f.rs;
    rt    = f.rt;
    rd    = f.rd;
    s     = f.shamt;
    funct = f.funct;
    imm16 = f.imm16;
    imm26 = f.imm26;
  end

endmodule

// File: rtl/instr_queue_split.sv
// F->D instruction queue presenting the head entry pre-split into MIPS fields.
// Optional same-cycle empty-queue bypass enabled by defining IQ_BYPASS_EN.
module instr_queue_split
  import instr_queue_split_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int INSTR_W = 32,
  parameter int PC_W    = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [INSTR_W-1:0]         in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [5:0]                 op,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 s,
  output logic [5:0]                 funct,
  output logic [15:0]                imm16,
  output logic [25:0]                imm26,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH-1);
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

  logic [INSTR_W-1:0] instr_mem_q [DEPTH];
  logic [PC_W-1:0]    pc_mem_q    [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic               bypass;
  logic               push;
  logic               pop;
  logic               mem_wr;
  logic [INSTR_W-1:0] head_instr;
  logic [PC_W-1:0]    head_pc;

  always_comb begin
    in_ready = (count_q < DEPTH_CNT) && !flush;
`ifdef IQ_BYPASS_EN
    bypass = (count_q == '0) && in_valid && !flush;
`else
    bypass = 1'b0;
`endif
    out_valid = ((count_q != '0) || bypass) && !flush;
    push      = in_valid && in_ready;
    // A bypassed entry is popped straight from the input, never from storage;
    // it is only stored when decode does not take it this cycle.
    pop       = out_valid && out_ready && !bypass;
    mem_wr    = push && !(bypass && out_ready);

    head_instr = bypass ? in_instr : instr_mem_q[rd_ptr_q];
    head_pc    = bypass ? in_pc    : pc_mem_q[rd_ptr_q];
    out_instr  = out_valid ? head_instr : INSTR_W'(NOP);
    out_pc     = out_valid ? head_pc    : '0;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (mem_wr) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
      case ({mem_wr, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset && mem_wr) begin
      instr_mem_q[wr_ptr_q] <= in_instr;
      pc_mem_q[wr_ptr_q]    <= in_pc;
    end
  end

  assign count = count_q;

  instr_field_split u_split (
    .instr (out_instr[31:0]),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .rd    (rd),
    .s     (s),
    .funct (funct),
    .imm16 (imm16),
    .imm26 (imm26)
  );

endmodule

// File: tb/tb_instr_queue_split.sv
// Scoreboard bench for instr_queue_split: directed stimulus, forked monitor checks every cycle.
module tb_instr_queue_split;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_instr, out_pc;
  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, s;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;

  ent_t sb[$];
  int   mcount = 0;

  always #5 clk = ~clk;

  instr_queue_split #(.DEPTH(DEPTH), .INSTR_W(32), .PC_W(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .op        (op),
    .rs        (rs),
    .rt        (rt),
    .rd        (rd),
    .s         (s),
    .funct     (funct),
    .imm16     (imm16),
    .imm26     (imm26),
    .count     (count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_head(input logic [31:0] i, input logic [31:0] p);
    chk("out_instr", out_instr, i);
    chk("out_pc",    out_pc,    p);
    chk("op",    32'(op),    32'(i[31:26]));
    chk("rs",    32'(rs),    32'(i[25:21]));
    chk("rt",    32'(rt),    32'(i[20:16]));
    chk("rd",    32'(rd),    32'(i[15:11]));
    chk("s",     32'(s),     32'(i[10:6]));
    chk("funct", 32'(funct), 32'(i[5:0]));
    chk("imm16", 32'(imm16), 32'(i[15:0]));
    chk("imm26", 32'(imm26), 32'(i[25:0]));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] i, input logic [31:0] p);
    in_valid = 1'b1;
    in_instr = i;
    in_pc    = p;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;

    fork
      begin : monitor
        logic exp_bypass, exp_valid, exp_ready, do_push, do_pop;
        ent_t head;
        forever begin
          @(negedge clk);
          if (!reset) begin
            sb.delete();
            mcount = 0;
          end else begin
            exp_ready = (mcount < DEPTH) && !flush;
`ifdef IQ_BYPASS_EN
            exp_bypass = (mcount == 0) && in_valid && !flush;
`else
            exp_bypass = 1'b0;
`endif
            exp_valid = ((mcount > 0) || exp_bypass) && !flush;
            chk("in_ready",  32'(in_ready),  32'(exp_ready));
            chk("out_valid", 32'(out_valid), 32'(exp_valid));
            chk("count",     32'(count),     32'(mcount));
            if (exp_bypass)     head = '{in_instr, in_pc};
            else if (exp_valid) head = sb[0];
            else                head = '{32'h0, 32'h0};
            chk_head(head.instr, head.pc);
            if (flush) begin
              sb.delete();
              mcount = 0;
            end else begin
              do_pop  = exp_valid && out_ready && !exp_bypass;
              do_push = in_valid && exp_ready && !(exp_bypass && out_ready);
              if (do_pop) void'(sb.pop_front());
              if (do_push) sb.push_back('{in_instr, in_pc});
              mcount = mcount + int'(do_push) - int'(do_pop);
            end
          end
        end
      end
      begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset for two cycles, then release
    tick(); tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_count",     32'(count),     32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_rs", 32'(rs), 32'd0);
    chk("rst_rt", 32'(rt), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_imm26", 32'(imm26), 32'd0);

    // add $8,$9,$10 visible the cycle after push
    tick();
    push(32'h012A4020, 32'h00003000);
    @(negedge clk);
    chk("add_valid", 32'(out_valid), 32'd1);
    chk("add_op",    32'(op),        32'd0);
    chk("add_rs",    32'(rs),        32'd9);
    chk("add_rt",    32'(rt),        32'd10);
    chk("add_rd",    32'(rd),        32'd8);
    chk("add_s",     32'(s),         32'd0);
    chk("add_funct", 32'(funct),     32'h20);
    chk("add_pc",    out_pc,         32'h00003000);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Fill to DEPTH, refused push during pop, refill across wrap, drain
    for (int i = 0; i < DEPTH; i++) push(32'h2000_0000 + i, 32'h100 + 4 * i);
    @(negedge clk);
    chk("full_count",    32'(count),    32'd4);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    tick();
    in_valid = 1'b1; in_instr = 32'h2000_0004; in_pc = 32'h110; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("refill_count", 32'(count), 32'd4);
    tick();
    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;

    // Streaming push+pop at occupancy 2
    push(32'h3000_0000, 32'h200);
    push(32'h3000_0001, 32'h204);
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 2; i < 12; i++) begin
      in_instr = 32'h3000_0000 + i;
      in_pc    = 32'h200 + 4 * i;
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("stream_count", 32'(count), 32'd2);
    tick(); tick();
    out_ready = 1'b0;

    // Flush with a concurrent push at occupancy 3
    for (int i = 0; i < 3; i++) push(32'h4000_0000 + i, 32'h300 + 4 * i);
    in_valid = 1'b1; flush = 1'b1; in_instr = 32'hDEADBEEF; in_pc = 32'h3FC;
    tick();
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("flush_count", 32'(count),     32'd0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    tick();
    push(32'h4100_0000, 32'h400);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-operation with occupancy 2
    push(32'h5000_0000, 32'h600);
    push(32'h5000_0001, 32'h604);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_count", 32'(count),     32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    tick();

    // lui $1,0x1001 presented to an empty queue with decode ready
    in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h3C011001; in_pc = 32'h500;
`ifdef IQ_BYPASS_EN
    @(negedge clk);
    chk("byp_valid", 32'(out_valid), 32'd1);
    chk("byp_op",    32'(op),        32'h0F);
    chk("byp_rt",    32'(rt),        32'd1);
    chk("byp_imm16", 32'(imm16),     32'h1001);
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("byp_count", 32'(count), 32'd0);
`else
    @(negedge clk);
    chk("nobyp_valid0", 32'(out_valid), 32'd0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("nobyp_valid1", 32'(out_valid), 32'd1);
    chk("nobyp_op",     32'(op),        32'h0F);
    chk("nobyp_rt",     32'(rt),        32'd1);
    chk("nobyp_imm16",  32'(imm16),     32'h1001);
    tick();
    out_ready = 1'b0;
    @(negedge clk);
    chk("nobyp_count", 32'(count), 32'd0);
`endif

    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_queue_split.md
Name: instr_queue_split

Overview:
- Parametrised instruction queue between the fetch (F) and decode (D) stages of the pipelined MIPS core.
- Buffers up to DEPTH fetched instruction/PC pairs and presents the head entry to decode, already split into MIPS fields (op, rs, rt, rd, shamt, funct, imm16, imm26).
- Decouples fetch from decode stalls; supports flush on branch/jump redirect.

Parameters:
- DEPTH, 4, number of queue entries; integer >= 2, any value (not restricted to powers of two).
- INSTR_W, 32, instruction width; fields below require 32.
- PC_W, 32, PC width carried alongside each instruction.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-low reset (0 = reset).
- flush  input  1  synchronous queue clear (redirect).
- in_valid  input  1  fetch presents an entry.
- in_ready  output  1  queue can accept an entry.
- in_instr  input  INSTR_W  fetched instruction.
- in_pc  input  PC_W  PC of the fetched instruction.
- out_valid  output  1  head entry valid to decode.
- out_ready  input  1  decode consumes the head.
- out_instr  output  INSTR_W  head instruction.
- out_pc  output  PC_W  head PC.
- op  output  6  instr[31:26].
- rs  output  5  instr[25:21].
- rt  output  5  instr[20:16].
- rd  output  5  instr[15:11].
- s  output  5  shamt, instr[10:6].
- funct  output  6  instr[5:0].
- imm16  output  16  instr[15:0].
- imm26  output  26  instr[25:0].
- count  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (reset==0 at a clock edge): wr_ptr=0, rd_ptr=0, count=0. Storage array is not cleared.
- Outputs while in reset and immediately after: out_valid=0, in_ready=1, and all field outputs, out_instr and out_pc read 0.
- Push: occurs when in_valid && in_ready.
  - Entry is written at wr_ptr.
  - wr_ptr wraps from DEPTH-1 to 0.
- Pop: occurs when out_valid && out_ready.
  - rd_ptr advances, wrapping from DEPTH-1 to 0.
- in_ready = (count < DEPTH) && !flush. No pop-through when full: a push with count==DEPTH is refused even if a pop occurs in the same cycle.
- out_valid = (count > 0) && !flush.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Output gating: out_instr, out_pc and all fields come from the head entry when out_valid=1, and are forced to 0 (NOP) when out_valid=0.
- Latency: a pushed entry is visible at the output on the next cycle, provided it is the oldest entry.
- Flush (priority below reset, above push/pop):
  - Pointers and count return to 0 at the edge.
  - Any push in the same cycle is discarded.
  - No pop occurs.
- Reset mid-operation: identical to power-on reset; contents discarded.
- Field split is purely combinational on the head entry, with fixed bit positions as listed in Ports.
- No unsigned/signed extension is performed here.

Optional Feature:
- Macro: IQ_BYPASS_EN.
- Defined:
  - When count==0 and in_valid && !flush, out_valid=1 in the same cycle.
  - Outputs and fields are taken combinationally from in_instr/in_pc.
  - If out_ready is also 1, the entry is consumed without being written; count stays 0.
  - If out_ready is 0, the entry is written normally.
- Undefined: no bypass; minimum latency is one cycle, as in Behaviour.

Decomposition:
- Shared package holds:
  - Field LSB/width constants (OP_LSB=26, RS_LSB=21, RT_LSB=16, RD_LSB=11, SH_LSB=6, FUNCT_LSB=0, IMM16_W=16, IMM26_W=26).
  - NOP encoding (32'h0).
- One natural sub-module: instr_field_split.
  - Combinational 32-bit instruction to field outputs.
  - Instantiated on the muxed head/bypass instruction.

Test Plan:
- Reset low for 2 cycles, then release → count=0, out_valid=0, in_ready=1, rs=rt=rd=0, imm26=0.
- Push 0x012A4020 (add $8,$9,$10) at PC 0x00003000, then idle → next cycle out_valid=1, op=0, rs=9, rt=10, rd=8, s=0, funct=0x20, out_pc=0x00003000.
- Push 4 entries with out_ready=0 → count=4, in_ready=0. A 5th push is refused while out_ready=1 pops one. Refill → wr_ptr wraps to 0 and entries pop in FIFO order.
- Hold in_valid=out_ready=1 for 10 cycles with count=2 → count stays 2 and the PC sequence pops in order.
- With count=3, assert flush together with in_valid=1 → next cycle count=0, out_valid=0, and the flushed-cycle entry never appears.
- Reset asserted with count=2 → count=0 next cycle. With IQ_BYPASS_EN, count=0, in_valid=out_ready=1 and in_instr=0x3C011001 → same-cycle out_valid=1, op=0x0F, rt=1, imm16=0x1001, count stays 0.
